// File: rtl/keypad_scan_if.sv
// Keypad scanner interface: matrix lines plus the decoded key/display bus.
// Combinational grouping only, no latency of its own.
// No backpressure: key_valid is a single-cycle strobe with no ready return.
interface keypad_scan_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] data_out;

    // Scanner side: reads rows, drives strobes and key results
    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_down,
        output data_out
    );

    // Keypad/consumer side
    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_down,
        input  data_out
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and a 4-code history register.
// Latency: key_valid one clk after the tick that completes DEBOUNCE_TICKS stable samples.
// No backpressure: key_valid is a one-cycle strobe; consumer must take it when it fires.
module keypad_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    // Active-low one-hot strobe for a column index
    function automatic logic [3:0] strobe(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-numbered row that is pulled low
    function automatic logic [1:0] row_index(input logic [3:0] p);
        if (!p[0])      return 2'd0;
        else if (!p[1]) return 2'd1;
        else if (!p[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;

    state_t        state;
    logic          started;
    logic [1:0]    col_idx;
    logic [1:0]    next_idx;
    logic [3:0]    pattern;
    logic [DW-1:0] deb_cnt;
    logic [3:0]    new_code;

    logic [3:0]    col_r;
    logic [3:0]    key_code_r;
    logic          key_valid_r;
    logic          key_down_r;
    logic [15:0]   data_r;

    assign tick     = (tick_cnt == TICK_LAST);
    assign next_idx = col_idx + 2'd1;
    // row_idx*4 + col_idx is just the two indices concatenated
    assign new_code = {row_index(row_sync), col_idx};

    // Scan tick divider: one-cycle tick every SCAN_DIV clocks
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Two-flop synchronizer for the asynchronous row lines (idle = all high)
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
        end
    end

    // Scan / debounce / held state machine with registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= SCAN;
            started     <= 1'b0;
            col_idx     <= 2'd0;
            pattern     <= 4'b1111;
            deb_cnt     <= '0;
            col_r       <= 4'b1111;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_down_r  <= 1'b0;
            data_r      <= 16'h0000;
        end else begin
            key_valid_r <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (!started) begin
                            // First tick only turns the strobes on; rows are not valid yet
                            started <= 1'b1;
                            col_r   <= strobe(col_idx);
                        end else if (row_sync != 4'b1111) begin
                            pattern <= row_sync;
                            if (DEBOUNCE_TICKS == 1) begin
                                key_code_r  <= new_code;
                                key_valid_r <= 1'b1;
                                key_down_r  <= 1'b1;
                                data_r      <= {data_r[11:0], new_code};
                                deb_cnt     <= '0;
                                state       <= HELD;
                            end else begin
                                deb_cnt <= DW'(1);
                                state   <= DEBOUNCE;
                            end
                        end else begin
                            col_idx <= next_idx;
                            col_r   <= strobe(next_idx);
                        end
                    end
                    DEBOUNCE: begin
                        if (row_sync == pattern) begin
                            if (deb_cnt + 1'b1 == DEB_LAST) begin
                                key_code_r  <= new_code;
                                key_valid_r <= 1'b1;
                                key_down_r  <= 1'b1;
                                data_r      <= {data_r[11:0], new_code};
                                deb_cnt     <= '0;
                                state       <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            // Bounce or change: drop the candidate and keep scanning
                            state   <= SCAN;
                            col_idx <= next_idx;
                            col_r   <= strobe(next_idx);
                        end
                    end
                    HELD: begin
                        if (row_sync == 4'b1111) begin
                            if (deb_cnt + 1'b1 == DEB_LAST) begin
                                key_down_r <= 1'b0;
                                deb_cnt    <= '0;
                                state      <= SCAN;
                                col_idx    <= next_idx;
                                col_r      <= strobe(next_idx);
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            // Any key still down (including a second one) restarts release
                            deb_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign kp.col       = col_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_down  = key_down_r;
    assign kp.data_out  = data_r;
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart to the team's multiplexed 4-digit seven-segment driver.
- The display driver walks active-low digit selects and drives segments. This block walks active-low column strobes of a 4x4 matrix keypad and reads back the active-low row lines.
- It debounces one key at a time and emits a 4-bit key code with a one-cycle valid strobe.
- It keeps a 16-bit shift register of the last four key codes, wired straight to the display driver's 16-bit data input.

Parameters:
SCAN_DIV  100000  clk cycles per scan tick; must be >= 4
DEBOUNCE_TICKS  20  consecutive stable tick samples required for press and for release; must be >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-high
row  input  4  keypad row lines, active-low (pulled up externally), asynchronous to clk
col  output  4  column strobes, active-low one-hot
key_code  output  4  code of last accepted key = row_idx*4 + col_idx
key_valid  output  1  one-cycle pulse when key_code is updated
key_down  output  1  high while an accepted key is held
data_out  output  16  last four key codes; newest in [3:0]

Behaviour:
- Reset (rst_n=1, async): col=4'b1111, key_code=0, key_valid=0, key_down=0, data_out=16'h0000, state=SCAN, col_idx=0, tick counter=0, debounce counter=0, synchronizer flops=4'b1111.
- Tick generator:
  - Counter runs 0..SCAN_DIV-1; tick is high for one clk when counter==SCAN_DIV-1, then counter wraps to 0.
  - First tick occurs SCAN_DIV cycles after reset release.
- Row input: 2-flop synchronizer; all decisions use synced row sampled on tick cycles only.
- Column index mapping: col_idx 0->4'b1110, 1->4'b1101, 2->4'b1011, 3->4'b0111.
- Row index mapping: row_idx = index of the lowest-numbered 0 bit of the sampled row.
- State SCAN:
  - First tick after reset drives col=4'b1110 (col_idx 0); no row sample is taken on that tick.
  - On each later tick, sample row. If row != 4'b1111: capture pattern=row, keep col frozen, set debounce count=1, go DEBOUNCE.
  - Otherwise advance col_idx (3 wraps to 0) and drive the new strobe.
- State DEBOUNCE:
  - On tick with row==pattern: count++. When count reaches DEBOUNCE_TICKS, go HELD.
  - On that transition, on the following clk edge: key_code = row_idx*4 + col_idx, key_valid=1 for exactly one cycle, key_down=1, data_out = {data_out[11:0], key_code_new}.
  - On tick with row != pattern (bounce, change, or release): go SCAN, advance col_idx, no output change.
  - DEBOUNCE_TICKS=1: acceptance occurs on the detection tick itself (SCAN goes directly to HELD).
- State HELD:
  - col stays frozen; key_down=1.
  - On tick with row==4'b1111: release count++. When it reaches DEBOUNCE_TICKS: key_down=0, go SCAN, advance col_idx.
  - On tick with row!=4'b1111: release count=0.
  - A second key pressed while held is ignored: no new key_valid, no auto-repeat.
- Multiple rows low simultaneously: the whole pattern must stay stable to qualify; code uses the lowest row index.
- key_code holds its value between presses. key_valid never asserts in consecutive cycles.
- Reset mid-operation (any state): all outputs return to reset values immediately; any partially debounced press is discarded.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3):
- Reset, no keys -> col=1111 until first tick, then 1110,1101,1011,0111,1110 every 4 cycles; key_valid never asserts, data_out=0000.
- Hold row=1101 only while col=1011 is strobed (col_idx 2, row_idx 1), stable -> exactly one key_valid pulse 2 ticks after the detection tick; key_code=6, data_out=0006, key_down=1.
- Keep the press active -> col stays 1011, no further key_valid. Release -> key_down falls on the 3rd consecutive all-high tick, then scanning resumes at col=0111.
- Bounce: row low for the detection tick, high on the next tick -> no key_valid; scanning continues from the next column.
- Four presses with codes 1, 2, 3, 15 (col0/row0 = code 0 as a fifth press) -> data_out sequence 0001, 0012, 0123, 123F, then 23F0; one key_valid per press.
- Assert rst_n during DEBOUNCE count=2 -> all outputs at reset values; after release of reset, no key_valid until a fresh full debounce completes.
